// File: rtl/inv_mix_columns_add_round_key_seq.sv
// inv_mix_columns_add_round_key_seq: AddRoundKey then InvMixColumns, one column per cycle, valid/ready in and out
module inv_mix_columns_add_round_key_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] roundKey,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] col;
  logic [127:0] st;
  logic [6:0] base;
  logic [31:0] col_out;
  logic accept;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[8*(3-i) +: 8];
      x2[i] = xt(x1[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ x1[i];
      mb[i] = x8[i] ^ x2[i] ^ x1[i];
      md[i] = x8[i] ^ x4[i] ^ x1[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
  // column 0 sits in the top 32 bits, so its bit offset is (3-col)*32
  assign base      = {~col, 5'b0};
  assign col_out   = inv_col(st[base +: 32]);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_state = st;
  assign accept    = in_valid & in_ready;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? (skip_mix ? DONE : MIX) : IDLE) :
               state == MIX  ? (col == 2'd3 ? DONE : MIX) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= 2'd0;
      st    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        st  <= in_state ^ roundKey;
        col <= 2'd0;
      end else if (state == MIX) begin
        st[base +: 32] <= col_out;
        col            <= col + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_add_round_key_seq.sv
// tb_inv_mix_columns_add_round_key_seq: directed and random checks against a GF(2^8) reference model
module tb_inv_mix_columns_add_round_key_seq;
  logic clk = 0, rst = 1, in_valid = 0, skip_mix = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] in_state = '0, roundKey = '0, out_state;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] exp_q [$];

  inv_mix_columns_add_round_key_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .roundKey(roundKey), .skip_mix(skip_mix),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  // shift-and-add product followed by long division by 0x11B
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  // generic column mix: out[r] = sum_j coef[(j-r) mod 4] * a[j]
  function automatic logic [127:0] mix(input logic [127:0] x, input logic [31:0] coefs);
    logic [7:0] b [16];
    logic [7:0] cf [4];
    logic [7:0] o [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = x[127 - 8*i -: 8];
    for (int i = 0; i < 4; i++) cf[i] = coefs[31 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        o[4*c + rr] = 8'h00;
        for (int j = 0; j < 4; j++) o[4*c + rr] ^= gm(cf[(j - rr + 4) % 4], b[4*c + j]);
      end
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = o[i];
    return r;
  endfunction

  function automatic logic [127:0] m_imc(input logic [127:0] x);
    return mix(x, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] m_mc(input logic [127:0] x);
    return mix(x, 32'h02030101);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
      else begin
        chk("out_state", out_state, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run(input logic [127:0] s, input logic [127:0] k, input logic skip,
                     input int hold, input logic early);
    int lat;
    exp_q.push_back(skip ? s ^ k : m_imc(s ^ k));
    in_state = s; roundKey = k; skip_mix = skip; in_valid = 1; out_ready = early;
    chk("in_ready_idle", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'($urandom); in_state = rnd128(); roundKey = rnd128(); skip_mix = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy", 128'(busy), 128'(1));
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), skip ? 128'(0) : 128'(4));
    for (int i = 0; i < hold; i++) begin
      out_ready = 0;
      chk("in_ready_done", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      in_valid = 1; in_state = rnd128();
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    chk("out_valid_clr", 128'(out_valid), 128'(0));
    chk("in_ready_back", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("pin_imc_a", m_imc({4{32'h046681e5}}), {4{32'hd4bf5d30}});
    chk("pin_imc_b", m_imc({4{32'h01010101}}), {4{32'h01010101}});
    chk("pin_imc_c", m_imc({4{32'hc6c6c6c6}}), {4{32'hc6c6c6c6}});
    chk("pin_mc_a", m_mc({4{32'hd4bf5d30}}), {4{32'h046681e5}});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    rst = 0;
    @(posedge clk); #1;
    run({4{32'h046681e5}}, '0, 0, 0, 0);
    chk("dir_028", out_state, {4{32'hd4bf5d30}});
    run({4{32'h01010101}}, '0, 0, 2, 1);
    chk("dir_029a", out_state, {4{32'h01010101}});
    run({4{32'hc6c6c6c6}}, '0, 0, 0, 1);
    chk("dir_029b", out_state, {4{32'hc6c6c6c6}});
    run(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1, 0, 0);
    chk("dir_030", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    run(rnd128(), rnd128(), 0, 10, 0);
    run(rnd128(), rnd128(), 1, 10, 1);
    in_state = rnd128(); roundKey = rnd128(); skip_mix = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 0;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_state", out_state, 128'h0);
    run({4{32'h046681e5}}, '0, 0, 1, 0);
    for (int n = 0; n < 1000; n++) begin
      logic [127:0] s, k;
      s = rnd128(); k = rnd128();
      chk("model_roundtrip", m_mc(m_imc(s ^ k)), s ^ k);
      run(s, k, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'($urandom));
    end
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
